// File: rtl/dma_request_latch_if.sv
// Request/acknowledge bundle between DMA sources, the request latch and the arbiter.
// The master side drives sources, modes, DACKs and clears; the slave side returns DRQs and status.
interface dma_request_latch_if #(
   parameter int CHANNELS = 4,
   parameter int CNT_W    = 3
);
   logic [CHANNELS-1:0]       src_in;
   logic [CHANNELS-1:0]       edge_mode;
   logic [CHANNELS-1:0]       dack_n;
   logic [CHANNELS-1:0]       clr;
   logic                      overflow_clr;
   logic [CHANNELS-1:0]       drq_out;
   logic [CHANNELS*CNT_W-1:0] pending;
   logic [CHANNELS-1:0]       overflow;

   modport master (
      output src_in, edge_mode, dack_n, clr, overflow_clr,
      input  drq_out, pending, overflow
   );

   modport slave (
      input  src_in, edge_mode, dack_n, clr, overflow_clr,
      output drq_out, pending, overflow
   );
endinterface

// File: rtl/dma_request_latch.sv
// Multi-channel DMA request generator: synchronises asynchronous sources and turns them
// into DRQs, either counting unserviced rising edges or passing a level straight through.
module dma_request_latch #(
   parameter int CHANNELS    = 4,
   parameter int SYNC_STAGES = 2,
   parameter int CNT_W       = 3
) (
   input  logic              clock,
   input  logic              reset,
   dma_request_latch_if.slave bus
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [CHANNELS-1:0]       sync_r [SYNC_STAGES];
   logic [SYNC_STAGES-1:0]    fill_r;
   logic [CHANNELS-1:0]       prev_src_r;
   logic [CHANNELS-1:0]       prev_dack_n_r;
   logic [CHANNELS-1:0]       mode_r;
   logic [CHANNELS-1:0]       drq_r;
   logic [CHANNELS-1:0]       ovf_r;
   logic [CNT_W-1:0]          cnt_r [CHANNELS];

   logic                      sync_valid_s;
   logic [CHANNELS-1:0]       src_s;
   logic [CHANNELS-1:0]       rise_s;
   logic [CHANNELS-1:0]       ack_s;
   logic [CHANNELS-1:0]       mode_chg_s;
   logic [CHANNELS-1:0]       drq_next_s;
   logic [CHANNELS-1:0]       ovf_next_s;
   logic [CNT_W-1:0]          cnt_next_s [CHANNELS];
   logic [CHANNELS*CNT_W-1:0] pending_s;

   // Source synchroniser chain plus a fill marker tracking which stages hold real samples.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < SYNC_STAGES; i++) begin
            sync_r[i] <= '0;
         end
         fill_r <= '0;
      end else begin
         sync_r[0] <= bus.src_in;
         fill_r[0] <= 1'b1;
         for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_r[i] <= sync_r[i-1];
            fill_r[i] <= fill_r[i-1];
         end
      end
   end

   // The reset zeros flushing out of the chain are not real source lows, so prev_src is
   // pinned high until the last stage carries a genuine sample; a source already high at
   // reset release then never looks like a rising edge.
   assign sync_valid_s = fill_r[SYNC_STAGES-1];
   assign src_s        = sync_r[SYNC_STAGES-1];
   assign rise_s       = src_s & ~prev_src_r;
   assign ack_s        = prev_dack_n_r & ~bus.dack_n;
   assign mode_chg_s   = mode_r ^ bus.edge_mode;

   // Per-channel next-state: clear/mode change first, then level pass-through or edge counting.
   always_comb begin
      drq_next_s = '0;
      ovf_next_s = bus.overflow_clr ? '0 : ovf_r;
      for (int i = 0; i < CHANNELS; i++) begin
         cnt_next_s[i] = cnt_r[i];
         if (bus.clr[i] || mode_chg_s[i]) begin
            cnt_next_s[i] = '0;
            drq_next_s[i] = 1'b0;
         end else if (!bus.edge_mode[i]) begin
            cnt_next_s[i] = '0;
            drq_next_s[i] = src_s[i];
         end else begin
            case ({rise_s[i], ack_s[i]})
               2'b10: begin
                  if (cnt_r[i] == CNT_MAX) begin
                     ovf_next_s[i] = 1'b1;
                  end else begin
                     cnt_next_s[i] = cnt_r[i] + CNT_W'(1);
                  end
               end
               2'b01: begin
                  if (cnt_r[i] != '0) begin
                     cnt_next_s[i] = cnt_r[i] - CNT_W'(1);
                  end else begin
                     cnt_next_s[i] = cnt_r[i];
                  end
               end
               default: cnt_next_s[i] = cnt_r[i];
            endcase
            drq_next_s[i] = (cnt_next_s[i] != '0) && bus.dack_n[i];
         end
      end
   end

   // Edge-detect history, mode copy, counters and registered outputs.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         prev_src_r    <= '1;
         prev_dack_n_r <= '1;
         mode_r        <= '0;
         drq_r         <= '0;
         ovf_r         <= '0;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_r[i] <= '0;
         end
      end else begin
         prev_src_r    <= sync_valid_s ? src_s : '1;
         prev_dack_n_r <= bus.dack_n;
         mode_r        <= bus.edge_mode;
         drq_r         <= drq_next_s;
         ovf_r         <= ovf_next_s;
         for (int i = 0; i < CHANNELS; i++) begin
            cnt_r[i] <= cnt_next_s[i];
         end
      end
   end

   // Flatten the per-channel counters onto the pending bus.
   always_comb begin
      pending_s = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         pending_s[i*CNT_W +: CNT_W] = cnt_r[i];
      end
   end

   assign bus.drq_out  = drq_r;
   assign bus.pending  = pending_s;
   assign bus.overflow = ovf_r;

endmodule

// File: tb/tb_dma_request_latch.sv
// Directed bench for dma_request_latch: reset behaviour, edge counting, DACK service,
// saturation/overflow, clear priority, level mode and asynchronous reset.
module tb_dma_request_latch;

   logic clock;
   logic reset;
   int   checks;
   int   errors;

   dma_request_latch_if #(.CHANNELS(4), .CNT_W(3)) bus ();

   dma_request_latch #(.CHANNELS(4), .SYNC_STAGES(2), .CNT_W(3)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic step();
      @(negedge clock);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [2:0] pend(input int ch);
      return bus.pending[ch*3 +: 3];
   endfunction

   // Two clocks high, two clocks low: one clean synchronised rising edge.
   task automatic pulse(input int ch);
      bus.src_in[ch] = 1'b1;
      step();
      step();
      bus.src_in[ch] = 1'b0;
      step();
      step();
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      reset            = 1'b1;
      bus.src_in       = 4'b0001;
      bus.edge_mode    = 4'hF;
      bus.dack_n       = 4'hF;
      bus.clr          = 4'h0;
      bus.overflow_clr = 1'b0;
      repeat (3) step();
      chk("reset_drq", 32'(bus.drq_out), 32'h0);
      chk("reset_pending", 32'(bus.pending), 32'h0);
      chk("reset_overflow", 32'(bus.overflow), 32'h0);

      // Source 0 already high at release must not produce an edge.
      reset = 1'b0;
      for (int i = 0; i < 20; i++) begin
         step();
         chk("release_drq", 32'(bus.drq_out), 32'h0);
         chk("release_pending", 32'(bus.pending), 32'h0);
      end

      // Ch1 single pulse: DRQ after three edges, then one DACK services it.
      bus.src_in[1] = 1'b1;
      step();
      chk("ch1_lat1", 32'(bus.drq_out[1]), 32'd0);
      step();
      chk("ch1_lat2", 32'(bus.drq_out[1]), 32'd0);
      step();
      chk("ch1_lat3", 32'(bus.drq_out[1]), 32'd1);
      chk("ch1_pend1", 32'(pend(1)), 32'd1);
      step();
      bus.src_in[1] = 1'b0;
      bus.dack_n[1] = 1'b0;
      step();
      chk("ch1_dack_drq", 32'(bus.drq_out[1]), 32'd0);
      chk("ch1_dack_pend", 32'(pend(1)), 32'd0);
      repeat (4) step();
      bus.dack_n[1] = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("ch1_after_dack", 32'(bus.drq_out[1]), 32'd0);
      end

      // Ch0: three queued edges, two DACK services.
      bus.src_in[0] = 1'b0;
      repeat (3) step();
      repeat (3) pulse(0);
      repeat (3) step();
      chk("ch0_pend3", 32'(pend(0)), 32'd3);
      chk("ch0_drq3", 32'(bus.drq_out[0]), 32'd1);
      bus.dack_n[0] = 1'b0;
      step();
      chk("ch0_dack1_drq", 32'(bus.drq_out[0]), 32'd0);
      chk("ch0_dack1_pend", 32'(pend(0)), 32'd2);
      step();
      chk("ch0_dack1_hold", 32'(bus.drq_out[0]), 32'd0);
      bus.dack_n[0] = 1'b1;
      step();
      chk("ch0_between", 32'(bus.drq_out[0]), 32'd1);
      step();
      bus.dack_n[0] = 1'b0;
      step();
      chk("ch0_dack2_drq", 32'(bus.drq_out[0]), 32'd0);
      chk("ch0_dack2_pend", 32'(pend(0)), 32'd1);
      bus.dack_n[0] = 1'b1;
      step();
      chk("ch0_after", 32'(bus.drq_out[0]), 32'd1);
      chk("ch0_after_pend", 32'(pend(0)), 32'd1);

      // Ch2 saturation and sticky overflow.
      repeat (9) pulse(2);
      chk("ch2_sat", 32'(pend(2)), 32'd7);
      chk("ch2_ovf", 32'(bus.overflow), 32'h4);
      bus.overflow_clr = 1'b1;
      step();
      bus.overflow_clr = 1'b0;
      chk("ch2_ovf_clr", 32'(bus.overflow), 32'h0);
      chk("ch2_pend_kept", 32'(pend(2)), 32'd7);
      chk("ch2_drq", 32'(bus.drq_out[2]), 32'd1);
      bus.clr[2] = 1'b1;
      step();
      bus.clr[2] = 1'b0;
      chk("ch2_clr_pend", 32'(pend(2)), 32'd0);
      chk("ch2_clr_drq", 32'(bus.drq_out[2]), 32'd0);

      // Ch3: rise and ack together leave the count alone; clr beats a rise.
      repeat (2) pulse(3);
      chk("ch3_pend2", 32'(pend(3)), 32'd2);
      chk("ch3_drq", 32'(bus.drq_out[3]), 32'd1);
      bus.src_in[3] = 1'b1;
      step();
      step();
      bus.dack_n[3] = 1'b0;
      step();
      chk("ch3_rise_ack", 32'(pend(3)), 32'd2);
      chk("ch3_rise_ack_drq", 32'(bus.drq_out[3]), 32'd0);
      bus.dack_n[3] = 1'b1;
      bus.src_in[3] = 1'b0;
      step();
      step();
      chk("ch3_hold", 32'(pend(3)), 32'd2);
      chk("ch3_redrq", 32'(bus.drq_out[3]), 32'd1);
      bus.src_in[3] = 1'b1;
      step();
      step();
      bus.clr[3] = 1'b1;
      step();
      bus.clr[3] = 1'b0;
      chk("ch3_clr_rise", 32'(pend(3)), 32'd0);
      chk("ch3_clr_drq", 32'(bus.drq_out[3]), 32'd0);
      bus.src_in[3] = 1'b0;
      step();
      step();
      chk("ch3_clr_after", 32'(pend(3)), 32'd0);

      // Ch1 level mode: 10-clock source gives 10-clock DRQ, three clocks late.
      bus.edge_mode[1] = 1'b0;
      step();
      bus.src_in[1] = 1'b1;
      for (int i = 1; i <= 14; i++) begin
         step();
         chk("ch1_level", 32'(bus.drq_out[1]), 32'((i >= 3 && i <= 12) ? 1 : 0));
         chk("ch1_level_pend", 32'(pend(1)), 32'd0);
         if (i == 10) begin
            bus.src_in[1] = 1'b0;
         end
      end
      bus.edge_mode[1] = 1'b1;
      step();
      chk("mode_ch0_pend", 32'(pend(0)), 32'd1);
      chk("mode_ch0_drq", 32'(bus.drq_out[0]), 32'd1);
      chk("mode_ch1_pend", 32'(pend(1)), 32'd0);
      step();
      chk("mode_ch1_drq", 32'(bus.drq_out[1]), 32'd0);

      // Asynchronous reset mid-operation, with a high source present at release.
      pulse(0);
      chk("pre_rst_pend", 32'(pend(0)), 32'd2);
      chk("pre_rst_drq", 32'(bus.drq_out[0]), 32'd1);
      bus.src_in[3] = 1'b1;
      #2;
      reset = 1'b1;
      #1;
      chk("async_rst_drq", 32'(bus.drq_out), 32'h0);
      chk("async_rst_pend", 32'(bus.pending), 32'h0);
      chk("async_rst_ovf", 32'(bus.overflow), 32'h0);
      step();
      step();
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         step();
         chk("post_rst_drq", 32'(bus.drq_out), 32'h0);
         chk("post_rst_pend", 32'(bus.pending), 32'h0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
